// File: rtl/pc_unit_pkg.sv
//----------------------------------------------------------------------------
// Module : pc_unit_pkg
// Brief  : Shared state encodings and next-PC select codes for the PC unit.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package pc_unit_pkg;

  typedef enum logic [1:0] {
    PC_BOOT   = 2'd0,
    PC_RUN    = 2'd1,
    PC_HALTED = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_J    = 3'd2,
    SEL_JR   = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_HOLD = 3'd5
  } pc_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
//----------------------------------------------------------------------------
// Module : pc_next_sel
// Brief  : Combinational next-PC priority selector and branch/jump target adders.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module pc_next_sel
  import pc_unit_pkg::*;
#(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 'h80,
  parameter bit              EXC_EN     = 1'b0
) (
  input  logic [1:0]       state_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_target_i,
  input  logic             jump_reg_i,
  input  logic [WIDTH-1:0] reg_target_i,
  input  logic             exc_req_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_plus_inc_i,
  output logic [2:0]       sel_o,
  output logic [WIDTH-1:0] next_pc_o
);

  localparam logic [WIDTH-1:0] c_LOW28 = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] w_br_target;
  logic [WIDTH-1:0] w_j_target;
  logic [WIDTH-1:0] w_jr_target;

  assign w_br_target = pc_plus_inc_i + (branch_offset_i << 2);
  // Region bits above bit 27 come from PC+INC; the rest from the instruction field.
  assign w_j_target  = (pc_plus_inc_i & ~c_LOW28) | WIDTH'({jump_target_i, 2'b00});
  assign w_jr_target = reg_target_i & ~WIDTH'(3);

  always_comb begin
    sel_o = SEL_HOLD;
    if (EXC_EN && exc_req_i && (state_i != PC_BOOT)) begin
      sel_o = SEL_EXC;
    end else if (state_i == PC_RUN) begin
      if (jump_reg_i) begin
        sel_o = (EXC_EN && (reg_target_i[1:0] != 2'b00)) ? SEL_EXC : SEL_JR;
      end else if (jump_i) begin
        sel_o = SEL_J;
      end else if (branch_taken_i) begin
        sel_o = SEL_BR;
      end else if (stall_i) begin
        sel_o = SEL_HOLD;
      end else begin
        sel_o = SEL_SEQ;
      end
    end
  end

  always_comb begin
    next_pc_o = pc_i;
    case (sel_o)
      SEL_SEQ:  next_pc_o = pc_plus_inc_i;
      SEL_BR:   next_pc_o = w_br_target;
      SEL_J:    next_pc_o = w_j_target;
      SEL_JR:   next_pc_o = w_jr_target;
      SEL_EXC:  next_pc_o = EXC_VECTOR;
      default:  next_pc_o = pc_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
//----------------------------------------------------------------------------
// Module : pc_unit
// Brief  : Program counter with boot/run/halted control and branch/jump redirect.
//          Define PC_EXC_EN to add exc_req/epc and exception redirect.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h80
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
`ifdef PC_EXC_EN
  input  logic             exc_req,
`endif
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             pc_valid
`ifdef PC_EXC_EN
  ,
  output logic [WIDTH-1:0] epc
`endif
);

`ifdef PC_EXC_EN
  localparam bit c_EXC_EN = 1'b1;
  logic w_exc_req;
  assign w_exc_req = exc_req;
`else
  localparam bit c_EXC_EN = 1'b0;
  logic w_exc_req;
  assign w_exc_req = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       w_sel;

  assign PC          = pc_q;
  assign pc_plus_inc = pc_q + WIDTH'(INC);

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR),
    .EXC_EN     (c_EXC_EN)
  ) u_next_sel (
    .state_i         (state_q),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .jump_reg_i      (jump_reg),
    .reg_target_i    (reg_target),
    .exc_req_i       (w_exc_req),
    .pc_i            (pc_q),
    .pc_plus_inc_i   (pc_plus_inc),
    .sel_o           (w_sel),
    .next_pc_o       (pc_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // An exception always lands in RUN, overriding a same-cycle halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_BOOT:   state_d = PC_RUN;
      PC_RUN: begin
        if (w_sel == SEL_EXC)  state_d = PC_RUN;
        else if (halt)         state_d = PC_HALTED;
      end
      PC_HALTED: begin
        if (w_sel == SEL_EXC)       state_d = PC_RUN;
        else if (resume && !halt)   state_d = PC_RUN;
      end
      default:   state_d = PC_BOOT;
    endcase
  end

  always_comb begin
    pc_valid = (state_q == PC_RUN);
  end

`ifdef PC_EXC_EN
  logic [WIDTH-1:0] epc_q, epc_d;

  assign epc_d = (w_sel == SEL_EXC) ? pc_q : epc_q;
  assign epc   = epc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) epc_q <= '0;
    else       epc_q <= epc_d;
  end
`endif

endmodule

`default_nettype wire
